// File: rtl/mvm_pkg.sv
// Shared definitions for the matrix-vector multiply block.
// Contents:
//   mvm_state_e      - controller state encoding
//   mvm_aw()         - full-precision result width from element width and dimension
//   MVM_*_DEFAULT    - default values of the top-level parameters
package mvm_pkg;

    localparam int MVM_N_DEFAULT  = 4;
    localparam int MVM_P_DEFAULT  = 4;
    localparam int MVM_DW_DEFAULT = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_X = 3'd1,
        ST_LOAD_A = 3'd2,
        ST_MAC    = 3'd3,
        ST_OUT    = 3'd4
    } mvm_state_e;

    // A sum of n products of two dw-bit signed values never exceeds this width.
    function automatic int mvm_aw(input int dw, input int n);
        return (2 * dw) + $clog2(n);
    endfunction

endpackage

// File: rtl/mvm_dot_lane.sv
// P-wide signed dot-product lane: P multipliers, one product register stage,
// then a combinational sum of the sign-extended products.
// Ports:
//   clk, reset  - clock, synchronous active-low reset
//   a_i, x_i    - P signed DW-bit operand pairs
//   psum_o      - signed AW-bit sum of the products presented one cycle earlier
module mvm_dot_lane
    import mvm_pkg::*;
#(
    parameter int P  = MVM_P_DEFAULT,
    parameter int DW = MVM_DW_DEFAULT,
    parameter int AW = mvm_aw(MVM_DW_DEFAULT, MVM_N_DEFAULT)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic signed [DW-1:0] a_i [P],
    input  logic signed [DW-1:0] x_i [P],
    output logic signed [AW-1:0] psum_o
);

    logic signed [2*DW-1:0] prod_d [P];
    logic signed [2*DW-1:0] prod_q [P];

    // Signed products; operands are both signed so the multiply is signed.
    always_comb begin
        for (int k = 0; k < P; k++) begin
            prod_d[k] = a_i[k] * x_i[k];
        end
    end

    // Product pipeline register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int k = 0; k < P; k++) begin
                prod_q[k] <= '0;
            end
        end else begin
            prod_q <= prod_d;
        end
    end

    // Sum of products, each sign-extended to the full result width first.
    always_comb begin
        psum_o = '0;
        for (int k = 0; k < P; k++) begin
            psum_o = psum_o + {{(AW - 2*DW){prod_q[k][2*DW-1]}}, prod_q[k]};
        end
    end

endmodule

// File: rtl/mvm_param.sv
// Streaming matrix-vector multiplier y = A * x with P parallel MAC lanes.
// Ports:
//   clk, reset        - clock, synchronous active-low reset
//   start             - begin a job (honoured only in IDLE, not in the done cycle)
//   s_valid/s_ready   - input handshake; s_data carries x[0..N-1] then A row-major
//   m_valid/m_ready   - output handshake; m_data carries y[0..N-1] in order
//   done              - one-cycle pulse after the y[N-1] handshake
// N must be at least 2 and divisible by P.
module mvm_param
    import mvm_pkg::*;
#(
    parameter int N  = MVM_N_DEFAULT,
    parameter int P  = MVM_P_DEFAULT,
    parameter int DW = MVM_DW_DEFAULT,
    localparam int AW = mvm_aw(DW, N)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic signed [DW-1:0] s_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic signed [AW-1:0] m_data,
    output logic                 done
);

    localparam int CPR = N / P;                       // chunks per row
    localparam int NCH = (N * N) / P;                 // chunks per matrix
    localparam int XW  = $clog2(N);
    localparam int IW  = $clog2(N * N);
    localparam int CW  = (CPR > 1) ? $clog2(CPR) : 1;
    localparam int MW  = $clog2(NCH + 2);

    mvm_state_e        state_q, state_d;
    logic              s_ready_q, s_ready_d;
    logic              m_valid_q, m_valid_d;
    logic signed [AW-1:0] m_data_q, m_data_d;
    logic              done_q, done_d;
    logic [IW-1:0]     ld_cnt_q, ld_cnt_d;
    logic [MW-1:0]     mac_cnt_q, mac_cnt_d;
    logic [CW-1:0]     rd_col_q, rd_col_d, wr_col_q, wr_col_d;
    logic [XW-1:0]     rd_row_q, rd_row_d, wr_row_q, wr_row_d;
    logic [XW-1:0]     out_idx_q, out_idx_d;
    logic signed [AW-1:0] acc_q, acc_d;

    logic signed [DW-1:0] x_mem  [N];
    logic signed [DW-1:0] a_mem  [N*N];
    logic signed [AW-1:0] y_mem  [N];
    logic signed [DW-1:0] x_rd_q [P];
    logic signed [DW-1:0] a_rd_q [P];
    logic [XW-1:0]        x_idx_s [P];
    logic [IW-1:0]        a_idx_s [P];

    logic                 s_acc_s, m_hs_s, issue_s, accum_s;
    logic                 wr_first_s, wr_last_s;
    logic signed [AW-1:0] psum_s, acc_sum_s;

    assign s_ready = s_ready_q;
    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign done    = done_q;

    // Handshakes and MAC pipeline qualifiers. Issue runs for NCH cycles; the
    // lane output for a chunk appears two cycles after its address was issued.
    always_comb begin
        s_acc_s    = s_valid && s_ready_q;
        m_hs_s     = m_valid_q && m_ready;
        issue_s    = (state_q == ST_MAC) && (mac_cnt_q < MW'(NCH));
        accum_s    = (state_q == ST_MAC) && (mac_cnt_q >= MW'(2));
        wr_first_s = (wr_col_q == '0);
        wr_last_s  = (wr_col_q == CW'(CPR - 1));
        acc_sum_s  = (wr_first_s ? '0 : acc_q) + psum_s;
    end

    // Read addresses for the P consecutive elements of the current chunk.
    always_comb begin
        for (int k = 0; k < P; k++) begin
            x_idx_s[k] = XW'(int'(rd_col_q) * P + k);
            a_idx_s[k] = IW'(int'(rd_row_q) * N + int'(rd_col_q) * P + k);
        end
    end

    // Operand memories: write on accepted beats, P registered read ports each.
    always_ff @(posedge clk) begin
        if (s_acc_s && (state_q == ST_LOAD_X)) begin
            x_mem[XW'(ld_cnt_q)] <= s_data;
        end
        if (s_acc_s && (state_q == ST_LOAD_A)) begin
            a_mem[ld_cnt_q] <= s_data;
        end
        for (int k = 0; k < P; k++) begin
            x_rd_q[k] <= x_mem[x_idx_s[k]];
            a_rd_q[k] <= a_mem[a_idx_s[k]];
        end
    end

    // Result buffer: a row is complete when its last chunk is accumulated.
    always_ff @(posedge clk) begin
        if (accum_s && wr_last_s) begin
            y_mem[wr_row_q] <= acc_sum_s;
        end
    end

    mvm_dot_lane #(
        .P  (P),
        .DW (DW),
        .AW (AW)
    ) u_lane (
        .clk    (clk),
        .reset  (reset),
        .a_i    (a_rd_q),
        .x_i    (x_rd_q),
        .psum_o (psum_s)
    );

    // Next state, counters, accumulator and output register inputs.
    always_comb begin
        state_d   = state_q;
        ld_cnt_d  = '0;
        mac_cnt_d = '0;
        rd_col_d  = '0;
        rd_row_d  = '0;
        wr_col_d  = '0;
        wr_row_d  = '0;
        acc_d     = '0;
        out_idx_d = '0;
        m_data_d  = '0;

        case (state_q)
            ST_IDLE: begin
                // done_q high means this is the done cycle: start is ignored.
                if (start && !done_q) begin
                    state_d = ST_LOAD_X;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD_X: begin
                if (s_acc_s) begin
                    if (ld_cnt_q == IW'(N - 1)) begin
                        state_d = ST_LOAD_A;
                    end else begin
                        ld_cnt_d = ld_cnt_q + IW'(1);
                    end
                end else begin
                    ld_cnt_d = ld_cnt_q;
                end
            end
            ST_LOAD_A: begin
                if (s_acc_s) begin
                    if (ld_cnt_q == IW'(N * N - 1)) begin
                        state_d = ST_MAC;
                    end else begin
                        ld_cnt_d = ld_cnt_q + IW'(1);
                    end
                end else begin
                    ld_cnt_d = ld_cnt_q;
                end
            end
            ST_MAC: begin
                mac_cnt_d = mac_cnt_q + MW'(1);
                if (issue_s) begin
                    if (rd_col_q == CW'(CPR - 1)) begin
                        rd_col_d = '0;
                        rd_row_d = rd_row_q + XW'(1);
                    end else begin
                        rd_col_d = rd_col_q + CW'(1);
                        rd_row_d = rd_row_q;
                    end
                end else begin
                    rd_col_d = rd_col_q;
                    rd_row_d = rd_row_q;
                end
                if (accum_s) begin
                    acc_d = acc_sum_s;
                    if (wr_last_s) begin
                        wr_col_d = '0;
                        wr_row_d = wr_row_q + XW'(1);
                    end else begin
                        wr_col_d = wr_col_q + CW'(1);
                        wr_row_d = wr_row_q;
                    end
                end else begin
                    acc_d    = acc_q;
                    wr_col_d = wr_col_q;
                    wr_row_d = wr_row_q;
                end
                // The last chunk is accumulated and written in cycle NCH+1.
                if (mac_cnt_q == MW'(NCH + 1)) begin
                    state_d = ST_OUT;
                end else begin
                    state_d = ST_MAC;
                end
            end
            ST_OUT: begin
                if (m_hs_s) begin
                    out_idx_d = out_idx_q + XW'(1);
                    if (out_idx_q == XW'(N - 1)) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_OUT;
                    end
                end else begin
                    out_idx_d = out_idx_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // y[0] is written well before the last row, so no bypass is needed
        // when entering OUT (N >= 2).
        if (state_d == ST_OUT) begin
            if ((state_q != ST_OUT) || m_hs_s) begin
                m_data_d = y_mem[out_idx_d];
            end else begin
                m_data_d = m_data_q;
            end
        end else begin
            m_data_d = '0;
        end

        s_ready_d = (state_d == ST_LOAD_X) || (state_d == ST_LOAD_A);
        m_valid_d = (state_d == ST_OUT);
        done_d    = (state_q == ST_OUT) && m_hs_s && (out_idx_q == XW'(N - 1));
    end

    // Control and output registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            s_ready_q <= 1'b0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            done_q    <= 1'b0;
            ld_cnt_q  <= '0;
            mac_cnt_q <= '0;
            rd_col_q  <= '0;
            rd_row_q  <= '0;
            wr_col_q  <= '0;
            wr_row_q  <= '0;
            out_idx_q <= '0;
            acc_q     <= '0;
        end else begin
            state_q   <= state_d;
            s_ready_q <= s_ready_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            done_q    <= done_d;
            ld_cnt_q  <= ld_cnt_d;
            mac_cnt_q <= mac_cnt_d;
            rd_col_q  <= rd_col_d;
            rd_row_q  <= rd_row_d;
            wr_col_q  <= wr_col_d;
            wr_row_q  <= wr_row_d;
            out_idx_q <= out_idx_d;
            acc_q     <= acc_d;
        end
    end

endmodule

// File: tb/tb_mvm_param.sv
// Bench for mvm_param: two instances (P=4 and P=2, N=4, DW=8) share the
// input stream and are checked against a plain-arithmetic A*x reference.
module tb_mvm_param;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int AW = 2 * DW + $clog2(N);
    localparam int P0 = 4;
    localparam int P1 = 2;
    localparam int NS = N + N * N;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 s_valid;
    logic signed [DW-1:0] s_data;
    logic                 start_v   [2];
    logic                 s_ready_v [2];
    logic                 m_valid_v [2];
    logic                 m_ready_v [2];
    logic signed [AW-1:0] m_data_v  [2];
    logic                 done_v    [2];

    logic signed [DW-1:0] stream [NS];
    longint               exp_y  [N];
    int                   n_checks = 0;
    int                   n_fail   = 0;
    int                   bad;

    always #5 clk = ~clk;

    mvm_param #(.N(N), .P(P0), .DW(DW)) u_dut_p4 (
        .clk(clk), .reset(reset), .start(start_v[0]),
        .s_valid(s_valid), .s_ready(s_ready_v[0]), .s_data(s_data),
        .m_valid(m_valid_v[0]), .m_ready(m_ready_v[0]), .m_data(m_data_v[0]),
        .done(done_v[0])
    );

    mvm_param #(.N(N), .P(P1), .DW(DW)) u_dut_p2 (
        .clk(clk), .reset(reset), .start(start_v[1]),
        .s_valid(s_valid), .s_ready(s_ready_v[1]), .s_data(s_data),
        .m_valid(m_valid_v[1]), .m_ready(m_ready_v[1]), .m_data(m_data_v[1]),
        .done(done_v[1])
    );

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Stream x = 0..N-1 followed by A = N..N+N*N-1 (i.e. x=0..3, A=4..19).
    task automatic fill_seq();
        for (int i = 0; i < NS; i++) stream[i] = DW'(i);
    endtask

    task automatic fill_const(input int v);
        for (int i = 0; i < NS; i++) stream[i] = DW'(v);
    endtask

    task automatic fill_random();
        for (int i = 0; i < NS; i++) stream[i] = DW'($urandom);
    endtask

    // Reference: y[i] = sum_j A[i][j] * x[j], A stored row-major after x.
    task automatic model();
        longint sum;
        for (int i = 0; i < N; i++) begin
            sum = 0;
            for (int j = 0; j < N; j++) begin
                sum += longint'(stream[N + i * N + j]) * longint'(stream[j]);
            end
            exp_y[i] = sum;
        end
    endtask

    task automatic pulse_start();
        start_v[0] = 1'b1;
        start_v[1] = 1'b1;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        start_v[1] = 1'b0;
    endtask

    // Push the whole stream, optionally with random s_valid gaps; start is
    // held high while beat start_beat is pending (must be ignored).
    task automatic load_job(input bit gaps, input int start_beat);
        int  idx   = 0;
        int  guard = 0;
        bit  rdy;
        while (idx < NS && guard < 2000) begin
            s_valid    = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            s_data     = stream[idx];
            start_v[0] = (idx == start_beat);
            start_v[1] = (idx == start_beat);
            rdy        = s_ready_v[0];
            @(posedge clk);
            if (s_valid && rdy) idx++;
            guard++;
            #1;
        end
        s_valid    = 1'b0;
        start_v[0] = 1'b0;
        start_v[1] = 1'b0;
        check_eq("load_beats", idx, NS);
    endtask

    // Called right after the last input beat: measures the MAC phase, then
    // drains y[] with an optional 3-cycle m_ready stall, then checks done.
    task automatic collect(input int d, input int stall_at, input bit start_out, input bit start_done);
        int     cyc = 0;
        longint held;
        while (!m_valid_v[d] && cyc < 500) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check_eq($sformatf("mac_cycles_p%0d", (d == 0) ? P0 : P1), cyc,
                 (N * N) / ((d == 0) ? P0 : P1) + 2);
        for (int i = 0; i < N; i++) begin
            if (i == stall_at) begin
                m_ready_v[d] = 1'b0;
                held = m_data_v[d];
                repeat (3) begin
                    @(posedge clk);
                    #1;
                    check_eq("stall_valid", m_valid_v[d], 1);
                    check_eq("stall_data", m_data_v[d], held);
                end
                m_ready_v[d] = 1'b1;
            end
            check_eq("m_valid", m_valid_v[d], 1);
            check_eq($sformatf("y%0d_dut%0d", i, d), m_data_v[d], exp_y[i]);
            start_v[d] = start_out && (i == 1);
            @(posedge clk);
            #1;
            start_v[d] = 1'b0;
        end
        check_eq("done_pulse", done_v[d], 1);
        check_eq("m_valid_after", m_valid_v[d], 0);
        start_v[d] = start_done;
        @(posedge clk);
        #1;
        start_v[d] = 1'b0;
        check_eq("done_low", done_v[d], 0);
        check_eq("idle_no_load", s_ready_v[d], 0);
    endtask

    task automatic run_job(input bit gaps, input int stall_at, input int start_beat,
                           input bit start_out, input bit start_done);
        pulse_start();
        load_job(gaps, start_beat);
        fork
            collect(0, stall_at, start_out, start_done);
            collect(1, stall_at, start_out, start_done);
        join
    endtask

    task automatic check_idle_outputs(input string tag);
        for (int d = 0; d < 2; d++) begin
            check_eq({tag, "_s_ready"}, s_ready_v[d], 0);
            check_eq({tag, "_m_valid"}, m_valid_v[d], 0);
            check_eq({tag, "_m_data"},  m_data_v[d],  0);
            check_eq({tag, "_done"},    done_v[d],    0);
        end
    endtask

    initial begin
        reset        = 1'b0;
        s_valid      = 1'b0;
        s_data       = '0;
        start_v[0]   = 1'b0;
        start_v[1]   = 1'b0;
        m_ready_v[0] = 1'b1;
        m_ready_v[1] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("rst");
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Basic job, steady handshakes.
        fill_seq();
        exp_y = '{38, 62, 86, 110};
        run_job(1'b0, -1, -1, 1'b0, 1'b0);

        // Extreme operands: 4 * (-128 * -128).
        fill_const(-128);
        exp_y = '{65536, 65536, 65536, 65536};
        run_job(1'b0, -1, -1, 1'b0, 1'b0);

        // Input gaps plus an output stall mid-stream.
        fill_seq();
        exp_y = '{38, 62, 86, 110};
        run_job(1'b1, 2, -1, 1'b0, 1'b0);

        // Abort a job during MAC; nothing from it may come out.
        fill_random();
        pulse_start();
        load_job(1'b1, -1);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        check_idle_outputs("abort");
        bad = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (m_valid_v[0] || m_valid_v[1] || done_v[0] || done_v[1] ||
                s_ready_v[0] || s_ready_v[1]) bad++;
        end
        check_eq("abort_quiet", bad, 0);
        fill_random();
        model();
        run_job(1'b1, 1, -1, 1'b0, 1'b0);

        // Start pulses in LOAD_A, OUT and the done cycle are ignored;
        // the next job follows immediately.
        fill_random();
        model();
        run_job(1'b1, -1, N + 3, 1'b1, 1'b1);
        fill_random();
        model();
        run_job(1'b0, -1, -1, 1'b0, 1'b0);

        for (int r = 0; r < 4; r++) begin
            fill_random();
            model();
            run_job(1'b1, int'($urandom_range(0, N - 1)), -1, 1'b0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
